bus_mem_responder: RTL

BUS_MEM_RESPONDER -- requirements
Module: bus_mem_responder

---
 rtl/bus_mem_responder.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/bus_mem_responder.sv
// bus_mem_responder: single-outstanding CPU bus slave backed by a word-addressed
// memory with byte strobes, configurable wait states and out-of-window error reporting.
module bus_mem_responder #(
    parameter logic [29:0] BASE_ADDR   = 30'h2100_0000,
    parameter int unsigned DEPTH_LOG2  = 8,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [29:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned ADDR_W = 30;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    // Only meaningful when WAIT_CYCLES > 0; the WAIT state is unreachable otherwise.
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES - 1);
    localparam bit NO_WAIT = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e              state_q;
    logic [CNT_W-1:0]    wait_cnt_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic                req_ready_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                rsp_err_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                accept;
    logic                commit;
    logic                mem_wr;
    logic                op_we;
    logic [ADDR_W-1:0]   op_addr;
    logic [DATA_W-1:0]   op_wdata;
    logic [STRB_W-1:0]   op_wstrb;
    logic [ADDR_W-1:0]   op_offset;
    logic                op_in_range;
    logic [DEPTH_LOG2-1:0] op_idx;
    logic [DATA_W-1:0]   rsp_rdata_d;
    logic                rsp_err_d;

    // Select the operation being committed (live request when no wait states), decode it.
    always_comb begin
        accept = req_valid && req_ready_q && (state_q == ST_IDLE) && !rst;
        if (state_q == ST_IDLE) begin
            op_we    = req_we;
            op_addr  = req_addr;
            op_wdata = req_wdata;
            op_wstrb = req_wstrb;
        end else begin
            op_we    = we_q;
            op_addr  = addr_q;
            op_wdata = wdata_q;
            op_wstrb = wstrb_q;
        end
        commit = (accept && NO_WAIT) || ((state_q == ST_WAIT) && (wait_cnt_q == '0));
        // Unsigned subtraction: addresses below the base wrap to huge offsets.
        op_offset   = op_addr - BASE_ADDR;
        op_in_range = (op_offset >> DEPTH_LOG2) == '0;
        op_idx      = op_offset[DEPTH_LOG2-1:0];
        mem_wr      = commit && op_we && op_in_range;
        rsp_rdata_d = (op_in_range && !op_we) ? mem_q[op_idx] : '0;
        rsp_err_d   = !op_in_range;
    end

    // Memory array: no reset, byte-strobed write on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (op_wstrb[b]) begin
                    mem_q[op_idx][8*b +: 8] <= op_wdata[8*b +: 8];
                end
            end
        end
    end

    // Transaction FSM with request capture, wait counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        we_q        <= req_we;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        wstrb_q     <= req_wstrb;
                        req_ready_q <= 1'b0;
                        if (NO_WAIT) begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= rsp_rdata_d;
                            rsp_err_q   <= rsp_err_d;
                        end else begin
                            state_q    <= ST_WAIT;
                            wait_cnt_q <= WAIT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt_q == '0) begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= rsp_rdata_d;
                        rsp_err_q   <= rsp_err_d;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    rsp_rdata_q <= '0;
                    rsp_err_q   <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
